// File: rtl/bayes_pkg.sv
// Shared types and constants for the Bayesian chip inference sequencer.
// Chip pin bundle, FSM states and readout timing live here.
package bayes_pkg;

    localparam int N_OBS              = 4;
    localparam int OBS_W              = 9;
    localparam int N_CLASS            = 4;
    localparam int ACC_W              = 16;
    localparam int FIFO_DEPTH         = 4;
    localparam int SEQ_READOUT_CYCLES = 11;
    localparam int SEQ_SAMPLE_FIRST   = 3;
    localparam int SEQ_PULSE_CYCLES   = 2;

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_SETUP, S_PRECH, S_PULSE, S_SEP, S_OFF,
        S_READOUT, S_ZERO, S_ACC, S_RESULT
    } state_t;

    typedef struct packed {
        logic       cwl;
        logic       csl;
        logic       inference;
        logic       read_8;
        logic       read_out;
        logic       load_mem;
        logic       stoch_log;
        logic [7:0] adr_full_col;
        logic [7:0] adr_full_row;
    } bm_chip_pins_t;

    localparam bm_chip_pins_t PINS_IDLE = '{
        cwl: 1'b0, csl: 1'b0, inference: 1'b0, read_8: 1'b0, read_out: 1'b0,
        load_mem: 1'b0, stoch_log: 1'b1, adr_full_col: 8'h00, adr_full_row: 8'h00
    };

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [7:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {{(ACC_W-7){1'b0}}, b};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/bayes_infer_sequencer_if.sv
// Host, result and chip-pin signals of the inference sequencer.
// master = host/chip side, slave = sequencer.
interface bayes_infer_sequencer_if;
    import bayes_pkg::*;

    logic [7:0]                 cfg_repeat;
    logic                       cfg_stoch_log;
    logic                       obs_valid;
    logic                       obs_ready;
    logic [N_OBS*OBS_W-1:0]     obs_data;
    logic                       res_valid;
    logic                       res_ready;
    logic [N_CLASS*ACC_W-1:0]   res_data;
    logic                       busy;
    logic                       chip_req;
    logic                       chip_gnt;
    logic                       cwl, csl, inference, read_8, read_out, load_mem, stoch_log;
    logic [7:0]                 adr_full_col;
    logic [7:0]                 adr_full_row;
    logic [N_CLASS-1:0]         bit_out;

    modport master (
        output cfg_repeat, cfg_stoch_log, obs_valid, obs_data, res_ready, chip_gnt, bit_out,
        input  obs_ready, res_valid, res_data, busy, chip_req,
        input  cwl, csl, inference, read_8, read_out, load_mem, stoch_log,
        input  adr_full_col, adr_full_row
    );

    modport slave (
        input  cfg_repeat, cfg_stoch_log, obs_valid, obs_data, res_ready, chip_gnt, bit_out,
        output obs_ready, res_valid, res_data, busy, chip_req,
        output cwl, csl, inference, read_8, read_out, load_mem, stoch_log,
        output adr_full_col, adr_full_row
    );

endinterface

// File: rtl/bayes_obs_fifo.sv
// Synchronous FIFO for observation sets; extra pointer bit distinguishes full from empty.
module bayes_obs_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;

    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty = (wp == rp);
    assign dout  = mem[rp[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + (AW+1)'(1);
            if (pop && !empty) rp <= rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/bayes_infer_sequencer.sv
// Inference scheduler: queues observation sets, owns the chip pins for N passes per set,
// reads out one byte per class each pass and returns the saturated per-class sums.
module bayes_infer_sequencer
    import bayes_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    bayes_infer_sequencer_if.slave bus
);
    state_t                        state, state_n;
    logic                          fifo_full, fifo_empty, pop, in_pass, stall;
    logic [N_OBS*OBS_W-1:0]        fifo_dout;
    logic [N_OBS-1:0][OBS_W-1:0]   cur_obs;
    logic [OBS_W-1:0]              obs_k;
    logic [1:0]                    k;
    logic [3:0]                    cnt;
    logic [7:0]                    pass, rep;
    logic                          stoch_q;
    logic [N_CLASS-1:0][7:0]       shreg;
    logic [N_CLASS-1:0][ACC_W-1:0] acc;
    bm_chip_pins_t                 pins;

    bayes_obs_fifo #(.W(N_OBS*OBS_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(bus.obs_valid), .din(bus.obs_data), .pop(pop),
        .full(fifo_full), .empty(fifo_empty), .dout(fifo_dout)
    );

    assign pop     = (state == S_IDLE) && !fifo_empty;
    assign in_pass = state inside {S_SETUP, S_PRECH, S_PULSE, S_SEP, S_OFF, S_READOUT, S_ZERO, S_ACC};
    // Losing the grant mid-pass freezes the sequence in place rather than restarting it.
    assign stall   = in_pass && !bus.chip_gnt;
    assign obs_k   = cur_obs[k];

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (!fifo_empty) state_n = S_REQ;
            S_REQ:     if (bus.chip_gnt) state_n = S_SETUP;
            S_SETUP:   state_n = S_PRECH;
            S_PRECH:   state_n = S_PULSE;
            S_PULSE:   if (cnt == 4'(SEQ_PULSE_CYCLES-1)) state_n = S_SEP;
            S_SEP:     state_n = S_OFF;
            S_OFF:     state_n = (k == 2'd3) ? S_READOUT : S_SETUP;
            S_READOUT: if (cnt == 4'(SEQ_READOUT_CYCLES-1)) state_n = S_ZERO;
            S_ZERO:    state_n = S_ACC;
            S_ACC:     state_n = (pass + 8'd1 < rep) ? S_SETUP : S_RESULT;
            S_RESULT:  if (bus.res_ready) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
        if (stall) state_n = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            k       <= '0;
            pass    <= '0;
            rep     <= 8'd1;
            stoch_q <= 1'b1;
            cur_obs <= '0;
            shreg   <= '0;
            acc     <= '0;
        end else begin
            state <= state_n;
            if (!stall) cnt <= (state_n != state) ? 4'd0 : cnt + 4'd1;
            if (pop) begin
                cur_obs <= fifo_dout;
                rep     <= (bus.cfg_repeat == 8'd0) ? 8'd1 : bus.cfg_repeat;
                stoch_q <= bus.cfg_stoch_log;
                k       <= '0;
                pass    <= '0;
                acc     <= '0;
            end
            if (!stall) begin
                // k wraps 3->0 on the last OFF, ready for the next pass.
                if (state == S_OFF) k <= k + 2'd1;
                if (state == S_READOUT && cnt >= 4'(SEQ_SAMPLE_FIRST))
                    for (int c = 0; c < N_CLASS; c++) shreg[c] <= {shreg[c][6:0], bus.bit_out[c]};
                if (state == S_ACC) begin
                    for (int c = 0; c < N_CLASS; c++) acc[c] <= sat_add(acc[c], shreg[c]);
                    pass <= pass + 8'd1;
                end
            end
        end
    end

    always_comb begin
        pins = PINS_IDLE;
        if (state != S_IDLE) pins.stoch_log = stoch_q;
        if (state inside {S_SETUP, S_PRECH, S_PULSE, S_SEP, S_OFF}) begin
            pins.adr_full_col = {k, 3'b000, obs_k[2:0]};
            pins.adr_full_row = {2'b00, obs_k[8:3]};
        end
        case (state)
            S_PRECH:   begin pins.csl = 1'b1; pins.cwl = 1'b1; pins.read_8 = 1'b1; end
            S_PULSE:   begin pins.cwl = 1'b1; pins.read_8 = 1'b1; end
            S_SEP:     pins.cwl = 1'b1;
            S_OFF:     pins.inference = 1'b1;
            S_READOUT: begin pins.inference = 1'b1; pins.read_out = 1'b1; pins.read_8 = 1'b1; end
            S_ZERO:    begin pins.inference = 1'b1; pins.read_out = 1'b1; pins.load_mem = 1'b1; end
            default:   ;
        endcase
        if (stall) pins = '0;
    end

    assign bus.obs_ready    = !fifo_full;
    assign bus.res_valid    = (state == S_RESULT);
    assign bus.res_data     = acc;
    assign bus.busy         = (state != S_IDLE) || !fifo_empty;
    assign bus.chip_req     = (state == S_REQ) || in_pass;
    assign bus.cwl          = pins.cwl;
    assign bus.csl          = pins.csl;
    assign bus.inference    = pins.inference;
    assign bus.read_8       = pins.read_8;
    assign bus.read_out     = pins.read_out;
    assign bus.load_mem     = pins.load_mem;
    assign bus.stoch_log    = pins.stoch_log;
    assign bus.adr_full_col = pins.adr_full_col;
    assign bus.adr_full_row = pins.adr_full_row;

endmodule

// File: tb/tb_bayes_infer_sequencer.sv
// Directed bench for the inference sequencer: a pass-position model predicts every output each
// cycle, and hand-computed literals pin results, latency and addresses.
module tb_bayes_infer_sequencer;
    import bayes_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bayes_infer_sequencer_if bus ();
    bayes_infer_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;
    bit rnd_en = 1'b0;

    localparam logic [22:0] PINS_RST = 23'h010000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [22:0] pins_now();
        return {bus.csl, bus.cwl, bus.inference, bus.read_8, bus.read_out, bus.load_mem,
                bus.stoch_log, bus.adr_full_col, bus.adr_full_row};
    endfunction

    // ---------------- behavioural model: set queue + position within a 37-cycle pass
    typedef enum {M_IDLE, M_REQ, M_PASS, M_RES} mph_t;
    mph_t            mph;
    logic [35:0]     mq[$];
    logic [35:0]     m_obs;
    int              m_rep, m_pass, m_pos, m_sz;
    logic            m_stoch;
    int unsigned     m_acc[4];
    logic [7:0]      m_byte[4];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mph = M_IDLE;
            mq.delete();
            m_pos = 0;
            m_pass = 0;
        end else begin
            m_sz = mq.size();
            case (mph)
                M_IDLE: if (m_sz > 0) begin
                    m_obs   = mq.pop_front();
                    m_rep   = (bus.cfg_repeat == 8'd0) ? 1 : int'(bus.cfg_repeat);
                    m_stoch = bus.cfg_stoch_log;
                    m_pass  = 0;
                    for (int c = 0; c < 4; c++) m_acc[c] = 0;
                    mph = M_REQ;
                end
                M_REQ: if (bus.chip_gnt) begin
                    mph   = M_PASS;
                    m_pos = 0;
                end
                M_PASS: if (bus.chip_gnt) begin
                    if (m_pos >= 27 && m_pos <= 34)
                        for (int c = 0; c < 4; c++) m_byte[c] = {m_byte[c][6:0], bus.bit_out[c]};
                    if (m_pos == 36) begin
                        for (int c = 0; c < 4; c++) begin
                            m_acc[c] = m_acc[c] + m_byte[c];
                            if (m_acc[c] > 65535) m_acc[c] = 65535;
                        end
                        m_pass++;
                    end
                    m_pos++;
                    if (m_pos == 37) begin
                        m_pos = 0;
                        if (m_pass == m_rep) mph = M_RES;
                    end
                end
                M_RES: if (bus.res_ready) mph = M_IDLE;
                default: ;
            endcase
            if (bus.obs_valid && m_sz < 4) mq.push_back(bus.obs_data);
        end
    end

    // ---------------- compare process
    logic [5:0]  e_ctl;
    logic        e_st;
    logic [7:0]  e_col, e_row;
    logic [63:0] e_res;
    logic [8:0]  mo;
    int          mk, msub;

    always @(negedge clk) begin
        if (!rst) begin
            e_ctl = '0; e_st = 1'b1; e_col = '0; e_row = '0;
            if (mph != M_IDLE) e_st = m_stoch;
            if (mph == M_PASS) begin
                if (!bus.chip_gnt) e_st = 1'b0;
                else if (m_pos < 24) begin
                    mk = m_pos / 6; msub = m_pos % 6;
                    mo = m_obs[mk*9 +: 9];
                    e_col = {mk[1:0], 3'b000, mo[2:0]};
                    e_row = {2'b00, mo[8:3]};
                    case (msub)
                        1:       e_ctl = 6'b110100;
                        2, 3:    e_ctl = 6'b010100;
                        4:       e_ctl = 6'b010000;
                        5:       e_ctl = 6'b001000;
                        default: e_ctl = 6'b000000;
                    endcase
                end
                else if (m_pos < 35) e_ctl = 6'b001110;
                else if (m_pos == 35) e_ctl = 6'b001011;
            end
            check("pins", pins_now(), {e_ctl, e_st, e_col, e_row});
            check("chip_req", bus.chip_req, (mph == M_REQ || mph == M_PASS));
            check("res_valid", bus.res_valid, (mph == M_RES));
            check("obs_ready", bus.obs_ready, (mq.size() < 4));
            check("busy", bus.busy, (mph != M_IDLE || mq.size() > 0));
            if (mph == M_RES) begin
                for (int c = 0; c < 4; c++) e_res[c*16 +: 16] = m_acc[c][15:0];
                check("res_data", bus.res_data, e_res);
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_en) bus.bit_out = 4'($urandom_range(0, 15));
    endtask

    task automatic push_set(input logic [35:0] d);
        bit done = 1'b0;
        bus.obs_valid = 1'b1;
        bus.obs_data  = d;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            done = bus.obs_ready;
            tick();
        end
        bus.obs_valid = 1'b0;
        check("push_accept", done, 1);
    endtask

    task automatic wait_res(input int limit);
        int n = 0;
        while (!bus.res_valid && n < limit) begin tick(); n++; end
        check("res_seen", bus.res_valid, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 500) begin tick(); n++; end
        check("idle", bus.busy, 0);
    endtask

    logic [7:0] exp_col[4] = '{8'h04, 8'h45, 8'h80, 8'hC7};
    logic [7:0] exp_row[4] = '{8'h27, 8'h14, 8'h00, 8'h3F};

    initial begin
        int n, k, got;
        logic [7:0] pc, pr;
        bus.cfg_repeat = 8'd1; bus.cfg_stoch_log = 1'b1; bus.obs_valid = 1'b0; bus.obs_data = '0;
        bus.res_ready = 1'b1; bus.chip_gnt = 1'b1; bus.bit_out = '0;
        #2;
        check("rst_pins", pins_now(), PINS_RST);
        check("rst_ready", bus.obs_ready, 1);
        check("rst_res", {bus.res_valid, bus.res_data}, 65'd0);
        check("rst_req_busy", {bus.chip_req, bus.busy}, 2'b00);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // one pass, latency from grant
        bus.chip_gnt = 1'b0; bus.bit_out = 4'b0101;
        push_set(36'h0);
        n = 0;
        while (!bus.chip_req && n < 20) begin tick(); n++; end
        check("t2_req", bus.chip_req, 1);
        bus.chip_gnt = 1'b1;
        tick();
        n = 0;
        while (!bus.res_valid && n < 100) begin tick(); n++; end
        check("t2_latency", n, 37);
        check("t2_res", bus.res_data, 64'h0000_00FF_0000_00FF);
        wait_idle();

        // SETUP addresses for each array, stoch_log latched low
        bus.cfg_stoch_log = 1'b0;
        push_set({9'h1FF, 9'h000, 9'h0A5, 9'h13C});
        k = 0; n = 0; pc = '0; pr = '0;
        while (k < 4 && n < 200) begin
            tick(); n++;
            if (bus.csl) begin
                check("t4_col", pc, exp_col[k]);
                check("t4_row", pr, exp_row[k]);
                k++;
            end
            pc = bus.adr_full_col; pr = bus.adr_full_row;
        end
        check("t4_arrays", k, 4);
        wait_res(100);
        wait_idle();
        bus.cfg_stoch_log = 1'b1;

        // repeat 0 treated as 1; repeat 255 without saturation
        bus.bit_out = 4'b1111; bus.cfg_repeat = 8'd0;
        push_set(36'h123456789);
        wait_res(100);
        check("t3_rep0", bus.res_data, 64'h00FF_00FF_00FF_00FF);
        wait_idle();
        bus.cfg_repeat = 8'd255;
        push_set(36'h0);
        wait_res(10000);
        check("t3_rep255", bus.res_data, 64'hFE01_FE01_FE01_FE01);
        wait_idle();
        bus.cfg_repeat = 8'd1;

        // reset mid-PULSE, then a clean set
        push_set(36'h0);
        n = 0;
        while (!(bus.cwl && bus.read_8 && !bus.csl) && n < 50) begin tick(); n++; end
        check("t1_in_pulse", {bus.cwl, bus.read_8, bus.csl}, 3'b110);
        #2 rst = 1'b1;
        #1;
        check("t1_pins", pins_now(), PINS_RST);
        check("t1_flags", {bus.chip_req, bus.res_valid, bus.busy, bus.obs_ready}, 4'b0001);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.bit_out = 4'b1010;
        push_set(36'h0);
        wait_res(100);
        check("t1_next", bus.res_data, 64'h00FF_0000_00FF_0000);
        wait_idle();

        // grant drop during READOUT
        bus.bit_out = 4'b0011;
        push_set(36'h0);
        n = 0;
        while (!(bus.read_out && !bus.load_mem) && n < 100) begin tick(); n++; end
        repeat (3) tick();
        bus.chip_gnt = 1'b0;
        repeat (2) tick();
        check("t6_pins0", pins_now(), 23'd0);
        check("t6_req", bus.chip_req, 1);
        repeat (3) tick();
        bus.chip_gnt = 1'b1;
        wait_res(100);
        check("t6_res", bus.res_data, 64'h0000_0000_00FF_00FF);
        wait_idle();

        // queue fill, ignored push when full, in-order results with back-pressure
        bus.chip_gnt = 1'b0; bus.res_ready = 1'b0; bus.cfg_repeat = 8'd2; rnd_en = 1'b1;
        for (int i = 0; i < 5; i++) push_set(36'(i * 37 + 5));
        check("t5_full", bus.obs_ready, 0);
        bus.obs_valid = 1'b1; bus.obs_data = 36'hFFFFFFFFF;
        repeat (3) tick();
        bus.obs_valid = 1'b0;
        bus.chip_gnt = 1'b1;
        got = 0;
        for (int i = 0; i < 5; i++) begin
            wait_res(300);
            if (bus.res_valid) got++;
            repeat (10) tick();
            bus.res_ready = 1'b1;
            tick();
            bus.res_ready = 1'b0;
        end
        check("t5_results", got, 5);
        rnd_en = 1'b0; bus.res_ready = 1'b1;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
